fetch_request_unit: RTL and testbench

Producer side of the instruction-fetch interface: owns the PC, issues word requests to instruction memory over a valid/ready handshake, and buffers in-order responses. It presents one instruction per cycle to the IF pipeline register's `instruction_i`. It honours the same `stall` that register uses, and flushes on branch/jump redirect.

---
 rtl/fetch_request_unit_pkg.sv | 11 +
 rtl/fetch_request_unit_if.sv | 20 ++
 rtl/fetch_request_unit_fifo.sv | 49 ++++
 rtl/fetch_request_unit.sv | 95 +++++++++
 tb/tb_fetch_request_unit.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_request_unit_pkg.sv
// Shared types and constants for the instruction-fetch request path.
package fetch_pkg;
  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_request_unit_if.sv
// Instruction-memory request/response channel (valid/ready request, in-order responses).
interface fetch_request_unit_if;
  import fetch_pkg::*;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_data;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );
endinterface

// File: rtl/fetch_request_unit_fifo.sv
// Small synchronous FIFO; flush wins over push, pop of an empty FIFO is ignored.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       push_data,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = push && !flush;
  assign w_pop  = pop && !flush && (r_count != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= push_data;
  end

  assign count = r_count;
  assign head  = r_mem[r_rd];
endmodule

// File: rtl/fetch_request_unit.sv
// Fetch producer: owns the PC, issues credit-limited word requests, buffers in-order responses.
module fetch_request_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic                        redirect_valid,
  input  logic [XLEN-1:0]             redirect_pc,
  fetch_request_unit_if.master        mem_if,
  output logic [XLEN-1:0]             instruction_o,
  output logic [XLEN-1:0]             pc_o,
  output logic                        instr_valid_o
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;

  logic [CW-1:0]   w_count;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_entry;
  logic            w_pop;
  logic [CW:0]     w_credit;
  logic            w_req_valid;
  logic            w_acc;
  logic            w_rsp;
  logic            w_push;
  logic            w_valid;
  logic [CW-1:0]   w_out_next;
  logic [XLEN-1:0] w_redirect_pc;

  assign w_pop = !stall && (w_count != '0);

  // The slot freed by this cycle's pop is reusable at once, which keeps a
  // 1-cycle memory streaming at one instruction per cycle with DEPTH = 2.
  assign w_credit    = {1'b0, r_outstanding} + {1'b0, w_count} - (CW+1)'(w_pop);
  assign w_req_valid = rst && !redirect_valid && (w_credit < (CW+1)'(DEPTH));
  assign w_acc       = w_req_valid && mem_if.mem_req_ready;
  assign w_rsp       = mem_if.mem_rsp_valid;
  assign w_push      = w_rsp && (r_drop_cnt == '0) && !redirect_valid;
  assign w_out_next  = r_outstanding + CW'(w_acc) - CW'(w_rsp);
  assign w_redirect_pc = redirect_pc & ~XLEN'(3);

  assign mem_if.mem_req_valid = w_req_valid;
  assign mem_if.mem_req_addr  = r_pc;

  // Responses that survive the drop counter belong to consecutive PCs issued
  // since the last redirect, so one running PC replaces a per-request tag queue.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc          <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (redirect_valid) begin
        r_pc       <= w_redirect_pc;
        r_rsp_pc   <= w_redirect_pc;
        r_drop_cnt <= w_out_next;
      end else begin
        if (w_acc)  r_pc     <= r_pc + XLEN'(INSTR_BYTES);
        if (w_push) r_rsp_pc <= r_rsp_pc + XLEN'(INSTR_BYTES);
        if (w_rsp && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CW'(1);
      end
    end
  end

  assign w_push_entry = '{pc: r_rsp_pc, instr: mem_if.mem_rsp_data};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .pop       (w_pop),
    .flush     (redirect_valid),
    .push_data (w_push_entry),
    .count     (w_count),
    .head      (w_head)
  );

  assign w_valid       = rst && (w_count != '0);
  assign instr_valid_o = w_valid;
  assign instruction_o = w_valid ? w_head.instr : NOP_INSTR;
  assign pc_o          = w_valid ? w_head.pc : '0;
endmodule

// File: tb/tb_fetch_request_unit.sv
// Directed bench for fetch_request_unit: cycle table against a latency-programmable memory, plus a PC-wrap instance.
module tb_fetch_request_unit;
  import fetch_pkg::*;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instruction_o, pc_o, instruction2_o, pc2_o;
  logic        instr_valid_o, instr_valid2_o;

  fetch_request_unit_if mif ();
  fetch_request_unit_if mif2 ();

  fetch_request_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .mem_if(mif), .instruction_o(instruction_o),
    .pc_o(pc_o), .instr_valid_o(instr_valid_o)
  );

  fetch_request_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) u_wrap (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .mem_if(mif2), .instruction_o(instruction2_o),
    .pc_o(pc2_o), .instr_valid_o(instr_valid2_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic        r, s, rd;
    logic [31:0] rp;
    logic        rdy;
    int          lat;
    logic        erv;
    logic [31:0] eaddr;
    logic        eiv;
    logic [31:0] epc;
  } vec_t;

  pend_t       q[$];
  vec_t        tbl[$];
  int          cyc;
  logic        p2;
  logic [31:0] a2;
  int          n_pass;
  int          n_chk;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Drive one cycle's inputs (memory responses included) and let outputs settle.
  task automatic apply(input logic r, input logic s, input logic rd,
                       input logic [31:0] rp, input logic rdy, input int lat);
    rst = r; stall = s; redirect_valid = rd; redirect_pc = rp;
    mif.mem_req_ready = rdy; mif2.mem_req_ready = rdy;
    if (!r) begin
      q.delete();
      p2 = 1'b0;
    end
    if (q.size() > 0 && q[0].due <= cyc) begin
      mif.mem_rsp_valid = 1'b1;
      mif.mem_rsp_data  = mdata(q[0].addr);
      void'(q.pop_front());
    end else begin
      mif.mem_rsp_valid = 1'b0;
      mif.mem_rsp_data  = 32'h0;
    end
    mif2.mem_rsp_valid = p2;
    mif2.mem_rsp_data  = mdata(a2);
    #1;
    if (mif.mem_req_valid && mif.mem_req_ready)
      q.push_back('{mif.mem_req_addr, cyc + lat});
    p2 = mif2.mem_req_valid && rdy;
    a2 = mif2.mem_req_addr;
  endtask

  task automatic next();
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    n_pass = 0; n_chk = 0; cyc = 0; p2 = 1'b0; a2 = 32'h0;
    rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    mif.mem_req_ready = 1'b1; mif.mem_rsp_valid = 1'b0; mif.mem_rsp_data = 32'h0;
    mif2.mem_req_ready = 1'b1; mif2.mem_rsp_valid = 1'b0; mif2.mem_rsp_data = 32'h0;

    //              r s rd rp            rdy lat erv eaddr         eiv epc
    // reset, then streaming with 1-cycle memory
    tbl.push_back('{0,0,0, 32'h0,        1,  1,  0,  32'h0,        0,  32'h0});
    tbl.push_back('{0,0,0, 32'h0,        1,  1,  0,  32'h0,        0,  32'h0});
    tbl.push_back('{1,0,0, 32'h0,        1,  1,  1,  32'h0,        0,  32'h0});
    tbl.push_back('{1,0,0, 32'h0,        1,  1,  1,  32'h4,        0,  32'h0});
    tbl.push_back('{1,0,0, 32'h0,        1,  1,  1,  32'h8,        1,  32'h0});
    tbl.push_back('{1,0,0, 32'h0,        1,  1,  1,  32'hC,        1,  32'h4});
    tbl.push_back('{1,0,0, 32'h0,        1,  1,  1,  32'h10,       1,  32'h8});
    tbl.push_back('{1,0,0, 32'h0,        1,  1,  1,  32'h14,       1,  32'hC});
    // stall held 5 cycles: output frozen, requests stop at 2 held/in flight
    tbl.push_back('{1,1,0, 32'h0,        1,  1,  0,  32'h0,        1,  32'h10});
    tbl.push_back('{1,1,0, 32'h0,        1,  1,  0,  32'h0,        1,  32'h10});
    tbl.push_back('{1,1,0, 32'h0,        1,  1,  0,  32'h0,        1,  32'h10});
    tbl.push_back('{1,1,0, 32'h0,        1,  1,  0,  32'h0,        1,  32'h10});
    tbl.push_back('{1,1,0, 32'h0,        1,  1,  0,  32'h0,        1,  32'h10});
    tbl.push_back('{1,0,0, 32'h0,        1,  1,  1,  32'h18,       1,  32'h10});
    tbl.push_back('{1,0,0, 32'h0,        1,  1,  1,  32'h1C,       1,  32'h14});
    tbl.push_back('{1,0,0, 32'h0,        1,  1,  1,  32'h20,       1,  32'h18});
    tbl.push_back('{1,0,0, 32'h0,        1,  1,  1,  32'h24,       1,  32'h1C});
    // memory not ready for 3 cycles: address held
    tbl.push_back('{1,0,0, 32'h0,        0,  1,  1,  32'h28,       1,  32'h20});
    tbl.push_back('{1,0,0, 32'h0,        0,  1,  1,  32'h28,       1,  32'h24});
    tbl.push_back('{1,0,0, 32'h0,        0,  1,  1,  32'h28,       0,  32'h0});
    tbl.push_back('{1,0,0, 32'h0,        1,  1,  1,  32'h28,       0,  32'h0});
    tbl.push_back('{1,0,0, 32'h0,        1,  1,  1,  32'h2C,       0,  32'h0});
    tbl.push_back('{1,0,0, 32'h0,        1,  1,  1,  32'h30,       1,  32'h28});
    // 2-cycle memory, redirect with two in flight (one arriving that cycle)
    tbl.push_back('{0,0,0, 32'h0,        1,  2,  0,  32'h0,        0,  32'h0});
    tbl.push_back('{0,0,0, 32'h0,        1,  2,  0,  32'h0,        0,  32'h0});
    tbl.push_back('{1,0,0, 32'h0,        1,  2,  1,  32'h0,        0,  32'h0});
    tbl.push_back('{1,0,0, 32'h0,        1,  2,  1,  32'h4,        0,  32'h0});
    tbl.push_back('{1,0,1, 32'h103,      1,  2,  0,  32'h0,        0,  32'h0});
    tbl.push_back('{1,0,0, 32'h0,        1,  2,  1,  32'h100,      0,  32'h0});
    tbl.push_back('{1,0,0, 32'h0,        1,  2,  1,  32'h104,      0,  32'h0});
    tbl.push_back('{1,0,0, 32'h0,        1,  2,  0,  32'h0,        0,  32'h0});
    tbl.push_back('{1,0,0, 32'h0,        1,  2,  1,  32'h108,      1,  32'h100});
    tbl.push_back('{1,0,0, 32'h0,        1,  2,  1,  32'h10C,      1,  32'h104});
    tbl.push_back('{1,0,0, 32'h0,        1,  2,  0,  32'h0,        0,  32'h0});
    // redirect together with a response, stall and a non-empty FIFO
    tbl.push_back('{1,1,1, 32'h200,      1,  2,  0,  32'h0,        1,  32'h108});
    tbl.push_back('{1,0,0, 32'h0,        1,  2,  1,  32'h200,      0,  32'h0});
    tbl.push_back('{1,0,0, 32'h0,        1,  2,  1,  32'h204,      0,  32'h0});
    tbl.push_back('{1,0,0, 32'h0,        1,  2,  0,  32'h0,        0,  32'h0});
    tbl.push_back('{1,0,0, 32'h0,        1,  2,  1,  32'h208,      1,  32'h200});
    // reset mid-stream, restart from RESET_PC
    tbl.push_back('{0,0,0, 32'h0,        1,  1,  0,  32'h0,        0,  32'h0});
    tbl.push_back('{1,0,0, 32'h0,        1,  1,  1,  32'h0,        0,  32'h0});
    tbl.push_back('{1,0,0, 32'h0,        1,  1,  1,  32'h4,        0,  32'h0});
    tbl.push_back('{1,0,0, 32'h0,        1,  1,  1,  32'h8,        1,  32'h0});

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].r, tbl[i].s, tbl[i].rd, tbl[i].rp, tbl[i].rdy, tbl[i].lat);
      chk($sformatf("v%0d req_valid", i), {31'b0, mif.mem_req_valid}, {31'b0, tbl[i].erv});
      if (tbl[i].erv)
        chk($sformatf("v%0d req_addr", i), mif.mem_req_addr, tbl[i].eaddr);
      chk($sformatf("v%0d instr_valid", i), {31'b0, instr_valid_o}, {31'b0, tbl[i].eiv});
      if (tbl[i].eiv) begin
        chk($sformatf("v%0d pc_o", i), pc_o, tbl[i].epc);
        chk($sformatf("v%0d instruction", i), instruction_o, mdata(tbl[i].epc));
      end else begin
        chk($sformatf("v%0d instruction_nop", i), instruction_o, NOP_INSTR);
      end
      next();
    end

    // reset outputs, then PC wrap on the RESET_PC = 0xFFFF_FFFC instance
    apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);
    chk("rst pc_o", pc_o, 32'h0);
    chk("rst instruction", instruction_o, NOP_INSTR);
    chk("rst wrap req_valid", {31'b0, mif2.mem_req_valid}, 32'h0);
    next();
    apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);
    next();
    apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1);
    chk("wrap req_valid", {31'b0, mif2.mem_req_valid}, 32'h1);
    chk("wrap addr first", mif2.mem_req_addr, 32'hFFFF_FFFC);
    next();
    apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1);
    chk("wrap addr second", mif2.mem_req_addr, 32'h0000_0000);
    next();
    apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1);
    chk("wrap addr third", mif2.mem_req_addr, 32'h0000_0004);
    chk("wrap instr_valid", {31'b0, instr_valid2_o}, 32'h1);
    chk("wrap pc_o first", pc2_o, 32'hFFFF_FFFC);
    chk("wrap instruction first", instruction2_o, mdata(32'hFFFF_FFFC));
    next();
    apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1);
    chk("wrap pc_o second", pc2_o, 32'h0000_0000);
    chk("wrap instruction second", instruction2_o, mdata(32'h0000_0000));
    next();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
